// File: rtl/buzz_pkg.sv
// buzz_pkg: shared FSM type, synchroniser floor and output-slice helper for buzz_monitor
package buzz_pkg;
  typedef enum logic [1:0] {ARMED, MEASURE, DONE} state_e;
  localparam int MIN_SYNC = 2;
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/buzz_chan.sv
// buzz_chan: one buzzer channel - synchronisers, edge counters, first-pulse timer, pair check
// Ports: clk, rst_n (async active-low); buzz_i/buzz_n_i raw drive lines; clr_i sync clear;
//        cnt_o/cnt_n_o saturating rise counts; high_time_o first-pulse width; done_o; pair_err_o
module buzz_chan
  import buzz_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int TIME_W      = 14,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CYC     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              buzz_i,
  input  logic              buzz_n_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  cnt_n_o,
  output logic [TIME_W-1:0] high_time_o,
  output logic              done_o,
  output logic              pair_err_o
);
  localparam int STG = (SYNC_STAGES < MIN_SYNC) ? MIN_SYNC : SYNC_STAGES;
  localparam int RW  = $clog2(ERR_CYC + 1);

  // STG synchroniser flops plus one retiming flop; the top bit is the synced level
  logic [STG:0]      sb_q, sn_q;
  logic              pb_q, pn_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cntn_q, cntn_d;
  logic [TIME_W-1:0] ht_q, ht_d;
  logic [RW-1:0]     run_q, run_d;
  logic              err_q, err_d;
  state_e            state_q, state_d;
  logic              lvl_b, lvl_n, rise_b, fall_b, rise_n;

  assign lvl_b  = sb_q[STG];
  assign lvl_n  = sn_q[STG];
  assign rise_b = lvl_b & ~pb_q;
  assign fall_b = ~lvl_b & pb_q;
  assign rise_n = lvl_n & ~pn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q    <= '0;
      sn_q    <= '0;
      pb_q    <= 1'b0;
      pn_q    <= 1'b0;
      cnt_q   <= '0;
      cntn_q  <= '0;
      ht_q    <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
      state_q <= ARMED;
    end else begin
      sb_q    <= {sb_q[STG-1:0], buzz_i};
      sn_q    <= {sn_q[STG-1:0], buzz_n_i};
      pb_q    <= lvl_b;
      pn_q    <= lvl_n;
      cnt_q   <= cnt_d;
      cntn_q  <= cntn_d;
      ht_q    <= ht_d;
      run_q   <= run_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // Clear wins over any edge decoded in the same cycle; previous-value flops still track
  always_comb begin
    cnt_d  = clr_i ? '0 : (rise_b && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    cntn_d = clr_i ? '0 : (rise_n && cntn_q != '1) ? cntn_q + CNT_W'(1) : cntn_q;
    run_d  = (clr_i || lvl_b != lvl_n) ? '0 : (run_q == RW'(ERR_CYC)) ? run_q : run_q + RW'(1);
    err_d  = !clr_i && (err_q || run_d == RW'(ERR_CYC));
  end

  always_comb begin
    state_d = state_q;
    ht_d    = ht_q;
    if (clr_i) begin
      state_d = ARMED;
      ht_d    = '0;
    end else begin
      case (state_q)
        ARMED: if (rise_b) begin
          state_d = MEASURE;
          ht_d    = TIME_W'(1);
        end
        MEASURE: if (fall_b) state_d = DONE;
                 else if (lvl_b && ht_q != '1) ht_d = ht_q + TIME_W'(1);
        default: ;
      endcase
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_n_o     = cntn_q;
  assign high_time_o = ht_q;
  assign done_o      = state_q == DONE;
  assign pair_err_o  = err_q;
endmodule

// File: rtl/buzz_monitor.sv
// buzz_monitor: NUM_CH independent buzzer channel monitors with packed status outputs
// Ports: clk, rst_n (async active-low); buzz/buzz_n per-channel raw lines; clr_cnt sync clear;
//        cnt/cnt_n/high_time packed per channel at [i*W +: W]; done, pair_err one bit per channel
module buzz_monitor
  import buzz_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 4,
  parameter int TIME_W      = 14,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CYC     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        buzz,
  input  logic [NUM_CH-1:0]        buzz_n,
  input  logic                     clr_cnt,
  output logic [NUM_CH*CNT_W-1:0]  cnt,
  output logic [NUM_CH*CNT_W-1:0]  cnt_n,
  output logic [NUM_CH*TIME_W-1:0] high_time,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        pair_err
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int CL = slice_lo(i, CNT_W);
    localparam int TL = slice_lo(i, TIME_W);
    buzz_chan #(
      .CNT_W(CNT_W), .TIME_W(TIME_W), .SYNC_STAGES(SYNC_STAGES), .ERR_CYC(ERR_CYC)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .buzz_i     (buzz[i]),
      .buzz_n_i   (buzz_n[i]),
      .clr_i      (clr_cnt),
      .cnt_o      (cnt[CL +: CNT_W]),
      .cnt_n_o    (cnt_n[CL +: CNT_W]),
      .high_time_o(high_time[TL +: TIME_W]),
      .done_o     (done[i]),
      .pair_err_o (pair_err[i])
    );
  end
endmodule

// File: tb/tb_buzz_monitor.sv
// tb_buzz_monitor: directed self-checking bench for buzz_monitor (3 channels, 4-bit timers)
module tb_buzz_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  buzz, buzz_n, done, pair_err;
  logic        clr_cnt;
  logic [11:0] cnt, cnt_n, high_time;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  buzz_monitor #(.NUM_CH(3), .CNT_W(4), .TIME_W(4), .SYNC_STAGES(2), .ERR_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .buzz(buzz), .buzz_n(buzz_n), .clr_cnt(clr_cnt),
    .cnt(cnt), .cnt_n(cnt_n), .high_time(high_time), .done(done), .pair_err(pair_err)
  );

  function automatic logic [3:0] c_of(input int ch);  return cnt[ch*4 +: 4];       endfunction
  function automatic logic [3:0] cn_of(input int ch); return cnt_n[ch*4 +: 4];     endfunction
  function automatic logic [3:0] ht_of(input int ch); return high_time[ch*4 +: 4]; endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear;
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
  endtask

  task automatic pulse(input int ch, input int w);
    buzz[ch] = 1'b1; buzz_n[ch] = 1'b0;
    tick(w);
    buzz[ch] = 1'b0; buzz_n[ch] = 1'b1;
    tick(5);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr_cnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      buzz = 3'(i); buzz_n = ~3'(i);
      tick(1);
    end
    n_chk++;
    if ({cnt, cnt_n, high_time, done, pair_err} !== 42'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", {cnt, cnt_n, high_time, done, pair_err});
    end
    buzz = '0; buzz_n = '0;
    tick(1);
    rst_n = 1'b1;
    tick(8);
    n_chk++;
    if ({cnt, cnt_n, high_time, done} !== 39'd0) begin
      n_fail++; $display("FAIL reset_idle_low got %h exp 0", {cnt, cnt_n, high_time, done});
    end
    buzz_n = '1; clr_cnt = 1'b1;
    tick(6);
    clr_cnt = 1'b0;
    tick(3);
    n_chk++;
    if ({cnt, cnt_n, high_time, done, pair_err} !== 42'd0) begin
      n_fail++; $display("FAIL reset_settled got %h exp 0", {cnt, cnt_n, high_time, done, pair_err});
    end
  endtask

  task automatic test_single_pulse;
    buzz[0] = 1'b1; buzz_n[0] = 1'b0;
    tick(5);
    buzz[0] = 1'b0; buzz_n[0] = 1'b1;
    tick(3);
    n_chk++;
    if (done[0] !== 1'b0) begin n_fail++; $display("FAIL done_early got %b exp 0", done[0]); end
    tick(1);
    n_chk++;
    if (done[0] !== 1'b1) begin n_fail++; $display("FAIL done_k3 got %b exp 1", done[0]); end
    n_chk++;
    if (ht_of(0) !== 4'd5) begin n_fail++; $display("FAIL ht_first got %0d exp 5", ht_of(0)); end
    n_chk++;
    if (c_of(0) !== 4'd1) begin n_fail++; $display("FAIL cnt_first got %0d exp 1", c_of(0)); end
    n_chk++;
    if (cn_of(0) !== 4'd1) begin n_fail++; $display("FAIL cntn_first got %0d exp 1", cn_of(0)); end
    pulse(0, 8);
    n_chk++;
    if (c_of(0) !== 4'd2) begin n_fail++; $display("FAIL cnt_second got %0d exp 2", c_of(0)); end
    n_chk++;
    if (ht_of(0) !== 4'd5 || done[0] !== 1'b1) begin
      n_fail++; $display("FAIL ht_frozen got %0d/%b exp 5/1", ht_of(0), done[0]);
    end
  endtask

  task automatic test_clear_priority;
    clear();
    buzz[0] = 1'b1; buzz_n[0] = 1'b0;
    tick(3);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    tick(2);
    n_chk++;
    if (c_of(0) !== 4'd0 || ht_of(0) !== 4'd0 || done[0] !== 1'b0) begin
      n_fail++; $display("FAIL clr_rise got cnt %0d ht %0d done %b exp 0/0/0", c_of(0), ht_of(0), done[0]);
    end
    buzz[0] = 1'b0; buzz_n[0] = 1'b1;
    tick(5);
    n_chk++;
    if (c_of(0) !== 4'd0 || done[0] !== 1'b0) begin
      n_fail++; $display("FAIL clr_armed got cnt %0d done %b exp 0/0", c_of(0), done[0]);
    end
    pulse(0, 3);
    n_chk++;
    if (c_of(0) !== 4'd1 || ht_of(0) !== 4'd3 || done[0] !== 1'b1) begin
      n_fail++; $display("FAIL clr_next got cnt %0d ht %0d done %b exp 1/3/1", c_of(0), ht_of(0), done[0]);
    end
  endtask

  task automatic test_pair;
    clear();
    buzz_n[0] = 1'b0;
    tick(3);
    buzz_n[0] = 1'b1;
    tick(6);
    n_chk++;
    if (pair_err[0] !== 1'b0) begin n_fail++; $display("FAIL pair_3cyc got %b exp 0", pair_err[0]); end
    buzz_n[0] = 1'b0;
    tick(4);
    buzz_n[0] = 1'b1;
    tick(6);
    n_chk++;
    if (pair_err !== 3'b001) begin n_fail++; $display("FAIL pair_4cyc got %b exp 001", pair_err); end
    tick(4);
    n_chk++;
    if (pair_err[0] !== 1'b1) begin n_fail++; $display("FAIL pair_sticky got %b exp 1", pair_err[0]); end
    clear();
    n_chk++;
    if (pair_err !== 3'b000) begin n_fail++; $display("FAIL pair_clr got %b exp 000", pair_err); end
  endtask

  task automatic test_saturation;
    clear();
    for (int i = 0; i < 20; i++) pulse(0, 2);
    n_chk++;
    if (c_of(0) !== 4'd15 || cn_of(0) !== 4'd15) begin
      n_fail++; $display("FAIL cnt_sat got %0d/%0d exp 15/15", c_of(0), cn_of(0));
    end
    n_chk++;
    if (ht_of(0) !== 4'd2) begin n_fail++; $display("FAIL ht_short got %0d exp 2", ht_of(0)); end
    buzz[1] = 1'b1; buzz_n[1] = 1'b0;
    tick(30);
    n_chk++;
    if (ht_of(1) !== 4'd15 || done[1] !== 1'b0) begin
      n_fail++; $display("FAIL ht_sat_mid got %0d/%b exp 15/0", ht_of(1), done[1]);
    end
    buzz[1] = 1'b0; buzz_n[1] = 1'b1;
    tick(5);
    n_chk++;
    if (ht_of(1) !== 4'd15 || done[1] !== 1'b1) begin
      n_fail++; $display("FAIL ht_sat_done got %0d/%b exp 15/1", ht_of(1), done[1]);
    end
  endtask

  task automatic test_independence;
    int exp_c[3];
    int exp_h[3];
    exp_c = '{3, 1, 2};
    exp_h = '{2, 6, 3};
    clear();
    for (int i = 0; i < 3; i++) pulse(0, 2);
    pulse(1, 6);
    for (int i = 0; i < 2; i++) pulse(2, 3);
    for (int ch = 0; ch < 3; ch++) begin
      n_chk++;
      if (c_of(ch) !== 4'(exp_c[ch]) || cn_of(ch) !== 4'(exp_c[ch]) || ht_of(ch) !== 4'(exp_h[ch])) begin
        n_fail++;
        $display("FAIL indep_ch%0d got cnt %0d cnt_n %0d ht %0d exp %0d/%0d/%0d",
                 ch, c_of(ch), cn_of(ch), ht_of(ch), exp_c[ch], exp_c[ch], exp_h[ch]);
      end
    end
    n_chk++;
    if (done !== 3'b111 || pair_err !== 3'b000) begin
      n_fail++; $display("FAIL indep_flags got done %b err %b exp 111/000", done, pair_err);
    end
    clear();
    n_chk++;
    if ({cnt, cnt_n, high_time, done, pair_err} !== 42'd0) begin
      n_fail++; $display("FAIL indep_clr got %h exp 0", {cnt, cnt_n, high_time, done, pair_err});
    end
  endtask

  task automatic test_reset_mid;
    buzz[2] = 1'b1; buzz_n[2] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    n_chk++;
    if ({cnt, high_time, done} !== 27'd0) begin
      n_fail++; $display("FAIL rst_mid got %h exp 0", {cnt, high_time, done});
    end
    rst_n = 1'b1;
    tick(6);
    buzz[2] = 1'b0; buzz_n[2] = 1'b1;
    tick(5);
    n_chk++;
    if (c_of(2) !== 4'd1 || ht_of(2) !== 4'd6 || done[2] !== 1'b1) begin
      n_fail++; $display("FAIL rst_release got cnt %0d ht %0d done %b exp 1/6/1", c_of(2), ht_of(2), done[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_clear_priority();
    test_pair();
    test_saturation();
    test_independence();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
